ntt_io_sequencer: RTL and testbench

NTT_IO_SEQUENCER -- requirements
Module: ntt_io_sequencer

---
 rtl/ntt_io_sequencer_if.sv | 29 ++
 rtl/ntt_io_sequencer.sv | 130 +++++++++++++
 tb/tb_ntt_io_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ntt_io_sequencer_if.sv
// Bundle of the stream and PU-side signals of the NTT I/O sequencer.
// master = sequencer side, slave = stream source/sink and PU side.
interface ntt_io_sequencer_if #(
  parameter int N = 17,
  parameter int D = 16
);
  logic           s_valid;
  logic           s_ready;
  logic [N-1:0]   s_data;
  logic           s_inv;
  logic           m_valid;
  logic           m_ready;
  logic [N-1:0]   m_data;
  logic           m_last;
  logic [D*N-1:0] pu_a;
  logic           pu_inv;
  logic           pu_start;
  logic [D*N-1:0] pu_an;

  modport master (
    input  s_valid, s_data, s_inv, m_ready, pu_an,
    output s_ready, m_valid, m_data, m_last, pu_a, pu_inv, pu_start
  );

  modport slave (
    output s_valid, s_data, s_inv, m_ready, pu_an,
    input  s_ready, m_valid, m_data, m_last, pu_a, pu_inv, pu_start
  );
endinterface

// File: rtl/ntt_io_sequencer.sv
// Serial-to-parallel loader, fixed-latency PU wait and parallel-to-serial
// drainer for one transform block of D coefficients at a time.
module ntt_io_sequencer #(
  parameter int N   = 17,
  parameter int D   = 16,
  parameter int LAT = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  ntt_io_sequencer_if.master    io,
  output logic                  busy
);
  localparam int DW = $clog2(D);
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] LAST_IDX = DW'(D - 1);
  localparam logic [LW-1:0] RUN_LAST = LW'(LAT - 1);

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t         state_r, state_nx_s;
  logic [DW-1:0]  beat_r, slot_r, slot_nx_s;
  logic [LW-1:0]  run_cnt_r;
  logic [D*N-1:0] pu_a_r, out_buf_r;
  logic [N-1:0]   m_data_r;
  logic           s_ready_r, m_valid_r, m_last_r, pu_inv_r, pu_start_r, busy_r;
  logic           accept_s, handshake_s;

  assign slot_nx_s   = slot_r + DW'(1);
  assign io.s_ready  = s_ready_r;
  assign io.m_valid  = m_valid_r;
  assign io.m_data   = m_data_r;
  assign io.m_last   = m_last_r;
  assign io.pu_a     = pu_a_r;
  assign io.pu_inv   = pu_inv_r;
  assign io.pu_start = pu_start_r;
  assign busy        = busy_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= LOAD;
    else      state_r <= state_nx_s;
  end

  // Next-state decode and handshake qualification
  always_comb begin
    state_nx_s  = state_r;
    accept_s    = 1'b0;
    handshake_s = 1'b0;
    case (state_r)
      LOAD: begin
        accept_s = io.s_valid && s_ready_r;
        if (accept_s && (beat_r == LAST_IDX)) state_nx_s = RUN;
        else                                  state_nx_s = LOAD;
      end
      RUN: begin
        if (run_cnt_r == RUN_LAST) state_nx_s = DRAIN;
        else                       state_nx_s = RUN;
      end
      DRAIN: begin
        handshake_s = m_valid_r && io.m_ready;
        if (handshake_s && (slot_r == LAST_IDX)) state_nx_s = LOAD;
        else                                     state_nx_s = DRAIN;
      end
      default: state_nx_s = LOAD;
    endcase
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_r     <= {DW{1'b0}};
      slot_r     <= {DW{1'b0}};
      run_cnt_r  <= {LW{1'b0}};
      pu_a_r     <= {(D*N){1'b0}};
      out_buf_r  <= {(D*N){1'b0}};
      m_data_r   <= {N{1'b0}};
      s_ready_r  <= 1'b0;
      m_valid_r  <= 1'b0;
      m_last_r   <= 1'b0;
      pu_inv_r   <= 1'b0;
      pu_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      // Flags are registered copies of the state being entered.
      s_ready_r  <= (state_nx_s == LOAD);
      m_valid_r  <= (state_nx_s == DRAIN);
      busy_r     <= (state_nx_s != LOAD);
      pu_start_r <= (state_r == LOAD) && (state_nx_s == RUN);
      case (state_r)
        LOAD: begin
          run_cnt_r <= {LW{1'b0}};
          if (accept_s) begin
            pu_a_r[int'(beat_r)*N +: N] <= io.s_data;
            if (beat_r == {DW{1'b0}}) pu_inv_r <= io.s_inv;
            if (beat_r == LAST_IDX) beat_r <= {DW{1'b0}};
            else                    beat_r <= beat_r + DW'(1);
          end
        end
        RUN: begin
          if (run_cnt_r == RUN_LAST) begin
            out_buf_r <= io.pu_an;
            m_data_r  <= io.pu_an[N-1:0];
            m_last_r  <= (LAST_IDX == {DW{1'b0}});
            slot_r    <= {DW{1'b0}};
            run_cnt_r <= {LW{1'b0}};
          end else begin
            run_cnt_r <= run_cnt_r + LW'(1);
          end
        end
        DRAIN: begin
          if (handshake_s) begin
            if (slot_r == LAST_IDX) begin
              slot_r   <= {DW{1'b0}};
              m_last_r <= 1'b0;
              m_data_r <= {N{1'b0}};
            end else begin
              slot_r   <= slot_nx_s;
              m_data_r <= out_buf_r[int'(slot_nx_s)*N +: N];
              m_last_r <= (slot_nx_s == LAST_IDX);
            end
          end
        end
        default: begin
          beat_r <= {DW{1'b0}};
          slot_r <= {DW{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_io_sequencer.sv
// Directed block sequence with random data against a block-level model:
// each output coefficient is the loaded coefficient plus the stub PU offset.
module tb_ntt_io_sequencer;
  localparam int N   = 17;
  localparam int D   = 16;
  localparam int LAT = 5;
  localparam int W   = D * N;
  localparam logic [N-1:0] JUNK = 17'h1ABCD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  logic [N-1:0]   blk [D];
  logic [N-1:0]   expv[D];
  logic [W-1:0]   pu_an_s;
  bit             hold_valid = 1'b0;

  ntt_io_sequencer_if #(.N(N), .D(D)) io ();

  ntt_io_sequencer #(.N(N), .D(D), .LAT(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .io   (io),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Stub PU: adds 1 per slot for forward, 3 for inverse direction.
  always_comb begin
    pu_an_s = '0;
    for (int k = 0; k < D; k++)
      pu_an_s[k*N +: N] = io.pu_a[k*N +: N] + (io.pu_inv ? 17'd3 : 17'd1);
  end
  assign io.pu_an = pu_an_s;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] packed_blk();
    logic [W-1:0] v;
    for (int k = 0; k < D; k++) v[k*N +: N] = blk[k];
    return v;
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_m_valid"},  W'(io.m_valid),  W'(0));
    chk({tag, "_s_ready"},  W'(io.s_ready),  W'(0));
    chk({tag, "_busy"},     W'(busy),        W'(0));
    chk({tag, "_m_last"},   W'(io.m_last),   W'(0));
    chk({tag, "_m_data"},   W'(io.m_data),   W'(0));
    chk({tag, "_pu_a"},     io.pu_a,         W'(0));
    chk({tag, "_pu_inv"},   W'(io.pu_inv),   W'(0));
    chk({tag, "_pu_start"}, W'(io.pu_start), W'(0));
  endtask

  task automatic load_block(input bit gaps, input bit inv0);
    int k = 0;
    int cyc = 0;
    while (k < D && cyc < 200) begin
      io.s_valid = gaps ? ((cyc % 3) != 2) : 1'b1;
      io.s_data  = blk[k];
      io.s_inv   = (k == 0) ? inv0 : !inv0;
      chk("load_s_ready", W'(io.s_ready), W'(1));
      chk("load_busy",    W'(busy),       W'(0));
      chk("load_m_valid", W'(io.m_valid), W'(0));
      @(posedge clk);
      if (io.s_valid) k++;
      cyc++;
      @(negedge clk);
    end
    chk("load_beats", W'(k), W'(D));
    io.s_valid = hold_valid;
    io.s_data  = JUNK;
    io.s_inv   = 1'b1;
  endtask

  task automatic run_phase(input bit inv0);
    chk("run_pu_start_first", W'(io.pu_start), W'(1));
    chk("run_s_ready",        W'(io.s_ready),  W'(0));
    chk("run_busy",           W'(busy),        W'(1));
    chk("run_pu_inv",         W'(io.pu_inv),   W'(inv0));
    for (int k = 0; k < D; k++) chk("run_pu_a_slot", W'(io.pu_a[k*N +: N]), W'(blk[k]));
    for (int c = 1; c < LAT; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("run_pu_start_later", W'(io.pu_start), W'(0));
      chk("run_m_valid",        W'(io.m_valid),  W'(0));
      chk("run_pu_a_stable",    io.pu_a,         packed_blk());
      chk("run_pu_inv_stable",  W'(io.pu_inv),   W'(inv0));
      chk("run_s_ready_held",   W'(io.s_ready),  W'(0));
    end
    @(posedge clk);
    @(negedge clk);
    chk("run_length_m_valid", W'(io.m_valid), W'(1));
  endtask

  task automatic drain_phase(input int mode, input int abort_j);
    int  j = 0;
    int  cyc = 0;
    bit  mr;
    while (j < D && cyc < 400) begin
      if (j == abort_j) begin
        #2 rst = 1'b0;
        #1 reset_checks("midrst");
        @(negedge clk);
        rst = 1'b1;
        io.m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rel_s_ready", W'(io.s_ready), W'(1));
        chk("midrst_rel_busy",    W'(busy),       W'(0));
        return;
      end
      mr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      io.m_ready = mr;
      chk("drain_m_valid", W'(io.m_valid), W'(1));
      chk("drain_m_data",  W'(io.m_data),  W'(expv[j]));
      chk("drain_m_last",  W'(io.m_last),  W'(j == D - 1));
      chk("drain_s_ready", W'(io.s_ready), W'(0));
      chk("drain_busy",    W'(busy),       W'(1));
      @(posedge clk);
      cyc++;
      if (mr) j++;
      @(negedge clk);
    end
    chk("drain_count", W'(j), W'(D));
    io.m_ready = 1'b0;
    chk("after_m_valid", W'(io.m_valid), W'(0));
    chk("after_s_ready", W'(io.s_ready), W'(1));
    chk("after_busy",    W'(busy),       W'(0));
  endtask

  task automatic do_block(input bit gaps, input bit inv0, input int mode, input int abort_j);
    for (int k = 0; k < D; k++) expv[k] = blk[k] + (inv0 ? 17'd3 : 17'd1);
    load_block(gaps, inv0);
    run_phase(inv0);
    drain_phase(mode, abort_j);
  endtask

  task automatic fill_random();
    for (int k = 0; k < D; k++) blk[k] = N'($urandom);
  endtask

  initial begin
    io.s_valid = 1'b0;
    io.s_data  = '0;
    io.s_inv   = 1'b0;
    io.m_ready = 1'b0;
    #1 reset_checks("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("por_rel_s_ready", W'(io.s_ready), W'(1));
    chk("por_rel_busy",    W'(busy),       W'(0));

    for (int k = 0; k < D; k++) blk[k] = N'(k);
    do_block(1'b0, 1'b0, 0, -1);

    for (int k = 0; k < D; k++) blk[k] = N'(100 + k);
    do_block(1'b0, 1'b0, 1, -1);

    fill_random();
    hold_valid = 1'b1;
    do_block(1'b1, 1'b1, 2, -1);
    hold_valid = 1'b0;

    fill_random();
    do_block(1'b0, 1'b0, 0, -1);

    fill_random();
    do_block(1'b1, 1'b0, 2, 5);

    fill_random();
    do_block(1'b0, 1'b1, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
